// File: rtl/main_memory_controller.sv
// Single-port word memory behind a four-phase RD/WR request/acknowledge handshake,
// with a programmable number of wait states inserted before every access.
module main_memory_controller #(
  parameter int DATAWIDTH_BUS     = 32,
  parameter int DATAWIDTH_ADDRESS = 8,
  parameter int WAIT_STATES       = 2
) (
  input  logic                         MAIN_MEMORY_CONTROLLER_CLOCK_50,
  input  logic                         MAIN_MEMORY_CONTROLLER_RESET_InLow,
  input  logic                         MAIN_MEMORY_CONTROLLER_RD_In,
  input  logic                         MAIN_MEMORY_CONTROLLER_WR_In,
  input  logic [DATAWIDTH_ADDRESS-1:0] MAIN_MEMORY_CONTROLLER_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]     MAIN_MEMORY_CONTROLLER_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0]     MAIN_MEMORY_CONTROLLER_data_OutBUS,
  output logic                         MAIN_MEMORY_CONTROLLER_ACK_Out,
  output logic                         MAIN_MEMORY_CONTROLLER_ERROR_Out,
  output logic [1:0]                   o_dbg_state
);

  // Handshake: a request is one of RD/WR held high while the other is low. It is
  // latched on the first IDLE edge that sees it; ACK rises after WAIT_STATES+1 edges
  // and stays high while the latched request line stays high, then drops at the first
  // edge sampling that line low. RD and WR together in IDLE is an error, not a request.

  localparam int DEPTH = 1 << DATAWIDTH_ADDRESS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]                   r_state;
  logic [3:0]                   r_cnt;
  logic                         r_op_wr;
  logic [DATAWIDTH_ADDRESS-1:0] r_addr;
  logic [DATAWIDTH_BUS-1:0]     r_wdata;
  logic [DATAWIDTH_BUS-1:0]     r_rdata;
  logic                         r_ack;
  logic                         r_err;

  // Contents survive reset; only the time-zero value is defined.
  logic [DATAWIDTH_BUS-1:0]     r_mem [DEPTH] = '{default: '0};

  logic w_rd;
  logic w_wr;
  logic w_req_one;
  logic w_req_both;
  logic w_req_line;
  logic w_mem_we;

  assign w_rd       = MAIN_MEMORY_CONTROLLER_RD_In;
  assign w_wr       = MAIN_MEMORY_CONTROLLER_WR_In;
  assign w_req_one  = w_rd ^ w_wr;
  assign w_req_both = w_rd & w_wr;
  assign w_req_line = r_op_wr ? w_wr : w_rd;
  assign w_mem_we   = (r_state == ST_ACCESS) && r_op_wr;

  always_ff @(posedge MAIN_MEMORY_CONTROLLER_CLOCK_50 or negedge MAIN_MEMORY_CONTROLLER_RESET_InLow) begin
    if (!MAIN_MEMORY_CONTROLLER_RESET_InLow) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_one) begin
            r_op_wr <= w_wr;
            r_addr  <= MAIN_MEMORY_CONTROLLER_ADDRESS_InBUS;
            r_wdata <= MAIN_MEMORY_CONTROLLER_data_InBUS;
            r_cnt   <= WAIT_LOAD;
            r_state <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end else if (w_req_both) begin
            r_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_op_wr) begin
            r_rdata <= r_mem[r_addr];
          end
          r_ack   <= 1'b1;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          if (!w_req_line) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write port has no reset: a reset before ACCESS simply never reaches this enable.
  always_ff @(posedge MAIN_MEMORY_CONTROLLER_CLOCK_50) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign MAIN_MEMORY_CONTROLLER_data_OutBUS = r_rdata;
  assign MAIN_MEMORY_CONTROLLER_ACK_Out     = r_ack;
  assign MAIN_MEMORY_CONTROLLER_ERROR_Out   = r_err;
  assign o_dbg_state                        = r_state;

endmodule

// File: tb/tb_main_memory_controller.sv
// Bench for main_memory_controller: two instances (2 and 0 wait states) driven by
// directed and random transactions, checked against a simple memory model.
module tb_main_memory_controller;

  logic        clk;
  logic        rst_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [7:0]  addr  [2];
  logic [31:0] wdat  [2];
  logic [31:0] dout  [2];
  logic        ack   [2];
  logic        err   [2];
  logic [1:0]  dbg   [2];

  int          total = 0;
  int          bad   = 0;

  // Reference model: flat word array per instance plus the last value a read returned.
  logic [31:0] model_mem [2][256];
  logic [31:0] last_read [2];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit          err_allow [2];
  logic        ack_prev  [2];

  main_memory_controller #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDRESS(8), .WAIT_STATES(2)) dut0 (
    .MAIN_MEMORY_CONTROLLER_CLOCK_50     (clk),
    .MAIN_MEMORY_CONTROLLER_RESET_InLow  (rst_n),
    .MAIN_MEMORY_CONTROLLER_RD_In        (rd[0]),
    .MAIN_MEMORY_CONTROLLER_WR_In        (wr[0]),
    .MAIN_MEMORY_CONTROLLER_ADDRESS_InBUS(addr[0]),
    .MAIN_MEMORY_CONTROLLER_data_InBUS   (wdat[0]),
    .MAIN_MEMORY_CONTROLLER_data_OutBUS  (dout[0]),
    .MAIN_MEMORY_CONTROLLER_ACK_Out      (ack[0]),
    .MAIN_MEMORY_CONTROLLER_ERROR_Out    (err[0]),
    .o_dbg_state                         (dbg[0])
  );

  main_memory_controller #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDRESS(8), .WAIT_STATES(0)) dut1 (
    .MAIN_MEMORY_CONTROLLER_CLOCK_50     (clk),
    .MAIN_MEMORY_CONTROLLER_RESET_InLow  (rst_n),
    .MAIN_MEMORY_CONTROLLER_RD_In        (rd[1]),
    .MAIN_MEMORY_CONTROLLER_WR_In        (wr[1]),
    .MAIN_MEMORY_CONTROLLER_ADDRESS_InBUS(addr[1]),
    .MAIN_MEMORY_CONTROLLER_data_InBUS   (wdat[1]),
    .MAIN_MEMORY_CONTROLLER_data_OutBUS  (dout[1]),
    .MAIN_MEMORY_CONTROLLER_ACK_Out      (ack[1]),
    .MAIN_MEMORY_CONTROLLER_ERROR_Out    (err[1]),
    .o_dbg_state                         (dbg[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_states(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic clear_lines(input int d);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d] === 1'b1 && ack_prev[d] !== 1'b1) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack dut%0d: got ack=1 expected no transaction", d);
        end else begin
          logic [31:0] e;
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("rdata_dut%0d", d), dout[d], e);
        end
      end
      if (err[d] === 1'b1 && !err_allow[d]) begin
        total++;
        bad++;
        $display("FAIL spurious_error dut%0d: got err=1 expected 0", d);
      end
      ack_prev[d] = ack[d];
    end
  end

  // ---------------- driver tasks ----------------
  // pulse=1: request dropped after the latching edge, with address/data scrambled and
  // both lines briefly high mid-transaction. pulse=0: held until ACK plus extra cycles.
  task automatic do_txn(input int d, input bit is_wr, input logic [7:0] a,
                        input logic [31:0] v, input bit pulse, input int extra);
    int  k;
    bit  got;
    if (is_wr) model_mem[d][a] = v;
    else       last_read[d] = model_mem[d][a];
    push_exp(d, last_read[d]);
    @(negedge clk);
    addr[d] = a;
    wdat[d] = v;
    rd[d]   = !is_wr;
    wr[d]   = is_wr;
    k   = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (pulse && k == 1) begin
        rd[d]   = 1'b1;
        wr[d]   = 1'b1;
        addr[d] = 8'($urandom);
        wdat[d] = $urandom;
      end else if (pulse && k == 2) begin
        clear_lines(d);
      end
      if (ack[d] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout dut%0d: got no ack in %0d cycles expected ack", d, k);
      clear_lines(d);
      repeat (4) @(negedge clk);
      return;
    end
    check($sformatf("latency_dut%0d", d), k, wait_states(d) + 2);
    if (!pulse) begin
      for (int i = 0; i < extra; i++) begin
        @(negedge clk);
        check("ack_held", ack[d], 1'b1);
      end
      clear_lines(d);
    end
    @(negedge clk);
    check("ack_cleared", ack[d], 1'b0);
  endtask

  task automatic do_error(input int d);
    @(negedge clk);
    err_allow[d] = 1'b1;
    rd[d] = 1'b1;
    wr[d] = 1'b1;
    addr[d] = 8'h10;
    wdat[d] = 32'hBAD0BAD0;
    @(negedge clk);
    check("error_pulse", err[d], 1'b1);
    check("error_no_ack", ack[d], 1'b0);
    clear_lines(d);
    @(negedge clk);
    check("error_one_cycle", err[d], 1'b0);
    err_allow[d] = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    last_read[0] = '0;
    last_read[1] = '0;
  endtask

  // Reset while dut0 sits in WAIT: the write must never land.
  task automatic reset_in_wait();
    @(negedge clk);
    addr[0] = 8'h05;
    wdat[0] = 32'hA5A5_5A5A;
    wr[0]   = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wait_dout", dout[0], 32'h0);
    check("rst_wait_ack", ack[0], 1'b0);
    check("rst_wait_err", err[0], 1'b0);
    clear_lines(0);
    release_reset();
  endtask

  // Reset while dut0 holds ACK: the write has already landed and must be kept.
  task automatic reset_in_ack(input logic [7:0] a, input logic [31:0] v);
    int k;
    model_mem[0][a] = v;
    push_exp(0, last_read[0]);
    @(negedge clk);
    addr[0] = a;
    wdat[0] = v;
    wr[0]   = 1'b1;
    k = 0;
    while (k < 40 && ack[0] !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check("rst_ack_seen", ack[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ack_cleared", ack[0], 1'b0);
    clear_lines(0);
    release_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clear_lines(d);
      addr[d] = '0;
      wdat[d] = '0;
      last_read[d] = '0;
      err_allow[d] = 1'b0;
      ack_prev[d]  = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[d][i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_dout", dout[d], 32'h0);
      check("reset_ack", ack[d], 1'b0);
      check("reset_err", err[d], 1'b0);
    end
    release_reset();

    // write then read back through the handshake
    do_txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 0);
    do_txn(0, 1'b0, 8'h10, 32'h0, 1'b0, 2);
    check("readback_10", dout[0], 32'hDEADBEEF);

    // illegal RD+WR in idle, contents of 0x10 untouched
    do_error(0);
    do_txn(0, 1'b0, 8'h10, 32'h0, 1'b0, 0);

    // single-cycle read pulse at the top address
    do_txn(0, 1'b0, 8'hFF, 32'h0, 1'b1, 0);

    // aborted write, then reading 0x05 returns its old contents
    reset_in_wait();
    do_txn(0, 1'b0, 8'h05, 32'h0, 1'b0, 0);
    check("abort_05", dout[0], 32'h0);

    // write followed by reset in ACK still lands
    reset_in_ack(8'h20, 32'hCAFEF00D);
    do_txn(0, 1'b0, 8'h20, 32'h0, 1'b0, 0);

    // intervening write leaves read data alone
    do_txn(0, 1'b1, 8'h00, 32'h12345678, 1'b0, 0);
    do_txn(0, 1'b0, 8'h00, 32'h0, 1'b0, 0);
    do_txn(0, 1'b1, 8'h01, 32'h87654321, 1'b0, 1);
    check("hold_after_write", dout[0], 32'h12345678);
    do_txn(0, 1'b0, 8'h00, 32'h0, 1'b1, 0);

    // zero-wait instance: pulse read with scrambled address after latching
    do_txn(1, 1'b1, 8'h33, 32'h0BADCAFE, 1'b0, 0);
    do_txn(1, 1'b0, 8'h33, 32'h0, 1'b1, 0);
    check("zero_wait_read", dout[1], 32'h0BADCAFE);
    do_error(1);

    // random traffic on both instances
    for (int i = 0; i < 60; i++) begin
      int          d;
      bit          w;
      logic [7:0]  a;
      d = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_txn(d, w, a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("queue0_drained", 32'(exp_q0.size()), 32'h0);
    check("queue1_drained", 32'(exp_q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_memory_controller.md
MAIN_MEMORY_CONTROLLER -- requirements
Module: main_memory_controller

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 32: data word width.
REQ-002 SHALL have parameter DATAWIDTH_ADDRESS, default 8: address width; array depth = 2^DATAWIDTH_ADDRESS words.
REQ-003 SHALL have parameter WAIT_STATES, default 2: idle cycles inserted before each access; legal range 0..15.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port MAIN_MEMORY_CONTROLLER_CLOCK_50  input  1: clock; all state changes occur on its rising edge.
REQ-006 SHALL have port MAIN_MEMORY_CONTROLLER_RESET_InLow  input  1: asynchronous active-low reset.
REQ-007 SHALL have port MAIN_MEMORY_CONTROLLER_RD_In  input  1: read request from control unit, level-held.
REQ-008 SHALL have port MAIN_MEMORY_CONTROLLER_WR_In  input  1: write request from control unit, level-held.
REQ-009 SHALL have port MAIN_MEMORY_CONTROLLER_ADDRESS_InBUS  input  DATAWIDTH_ADDRESS: word address.
REQ-010 SHALL have port MAIN_MEMORY_CONTROLLER_data_InBUS  input  DATAWIDTH_BUS: write data.
REQ-011 SHALL have port MAIN_MEMORY_CONTROLLER_data_OutBUS  output  DATAWIDTH_BUS: registered read data.
REQ-012 SHALL have port MAIN_MEMORY_CONTROLLER_ACK_Out  output  1: transaction-complete acknowledge, registered.
REQ-013 SHALL have port MAIN_MEMORY_CONTROLLER_ERROR_Out  output  1: one-cycle pulse on illegal request, registered.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACCESS, ACK.
REQ-015 IDLE: at a rising edge with exactly one of RD_In/WR_In high, SHALL latch operation, address and write data, load wait counter with WAIT_STATES, go to WAIT (or ACCESS if WAIT_STATES=0).
REQ-016 IDLE: at an edge with RD_In and WR_In both high, SHALL stay in IDLE, assert ERROR_Out for exactly one cycle, perform no access.
REQ-017 WAIT: SHALL decrement counter each edge; on counter reaching 1, next state ACCESS; total WAIT occupancy = WAIT_STATES cycles.
REQ-018 ACCESS (one cycle): read SHALL load array[latched address] into data_OutBUS; write SHALL store latched data into array[latched address]; ACK_Out SHALL be set to 1 at the same edge; next state ACK.
REQ-019 Latency: request sampled at edge 0 -> ACK_Out high after edge WAIT_STATES+1 (edge 3 with default).
REQ-020 ACK: ACK_Out SHALL remain 1 while the latched request line remains high; at the first edge sampling it low, ACK_Out SHALL clear and FSM SHALL return to IDLE (four-phase handshake).
REQ-021 Request or address/data changes after the latching edge SHALL NOT affect the transaction in progress; a request withdrawn early SHALL still complete, with ACK_Out high for exactly one cycle.
REQ-022 A new request SHALL be accepted no earlier than the edge after return to IDLE; back-to-back throughput = WAIT_STATES+3 cycles per transaction minimum.
REQ-023 data_OutBUS SHALL change only on read ACCESS; writes and idle cycles SHALL hold the last read value.
REQ-024 All 2^DATAWIDTH_ADDRESS addresses SHALL be valid; no wrap or range checking needed.
REQ-025 Array SHALL initialise to all zeros at time zero and SHALL NOT be cleared by reset.
REQ-026 ERROR_Out SHALL never assert outside IDLE; simultaneous RD/WR seen in WAIT/ACCESS/ACK SHALL be ignored.

Reset
REQ-027 On RESET_InLow low, asynchronously: state IDLE, counter 0, data_OutBUS 0, ACK_Out 0, ERROR_Out 0.
REQ-028 Reset asserted before the ACCESS edge SHALL abort the transaction with no array write; reset after ACCESS SHALL keep the written word.
REQ-029 After reset release, first request SHALL be sampled no earlier than the first rising edge with RESET_InLow high.

Verification
REQ-030 Write 0xDEADBEEF to addr 0x10 (WR held until ACK), then read addr 0x10 -> ACK after 3 edges each; data_OutBUS = 0xDEADBEEF.
REQ-031 RD and WR both high in IDLE -> ERROR_Out 1 for one cycle, ACK_Out stays 0, addr contents unchanged.
REQ-032 RD pulsed one cycle on addr 0xFF -> ACK_Out high exactly one cycle at edge 3, data_OutBUS = array[0xFF].
REQ-033 WR to addr 0x05 with reset asserted during WAIT -> outputs 0 immediately; subsequent read of 0x05 returns prior value (0x00000000).
REQ-034 WAIT_STATES=0 instance: read request -> ACK_Out high after edge 1; address changed after edge 0 does not alter returned data.
REQ-035 Write 0x12345678 to addr 0x00, then read addr 0x00 -> returns 0x12345678; intervening write to addr 0x01 leaves data_OutBUS unchanged.
